// File: rtl/dec_controller.sv
// Input-side sequencing controller of the RS decoder: tracks codeword position of each
// received beat, flags codeword end/start lanes and forwards the beat through a register slice.
module dec_controller #(
    parameter int RS_COD_LEN  = 255,
    parameter int DEC_SYM_NUM = 16,
    parameter int SYM_WID     = 8,
    localparam int CNT_W      = $clog2(RS_COD_LEN + 1),
    localparam int LANE_W     = (DEC_SYM_NUM > 1) ? $clog2(DEC_SYM_NUM) : 1,
    localparam int DAT_W      = DEC_SYM_NUM * SYM_WID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DAT_W-1:0]  in_data,
    input  logic              dec_flush,
    output logic [1:0]        dec_phase,
    output logic [CNT_W-1:0]  dec_counter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DAT_W-1:0]  out_data,
    output logic              out_end,
    output logic [LANE_W-1:0] out_end_lane,
    output logic              out_start,
    output logic [LANE_W-1:0] out_start_lane,
    output logic [15:0]       cw_count
);

    typedef enum logic [1:0] {
        CON_IDL = 2'd0,
        CON_PRE = 2'd1,
        CON_WOR = 2'd2,
        CON_DRN = 2'd3
    } con_phase_e;

    localparam logic [CNT_W:0]   N_EXT   = (CNT_W + 1)'(DEC_SYM_NUM);
    localparam logic [CNT_W:0]   L_EXT   = (CNT_W + 1)'(RS_COD_LEN);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(DEC_SYM_NUM);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DEC_SYM_NUM - 1);

    con_phase_e          phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DAT_W-1:0]    out_data_q, out_data_d;
    logic                out_end_q, out_end_d;
    logic [LANE_W-1:0]   out_end_lane_q, out_end_lane_d;
    logic                out_start_q, out_start_d;
    logic [LANE_W-1:0]   out_start_lane_q, out_start_lane_d;
    logic [15:0]         cw_q, cw_d;

    logic                accept;
    logic [CNT_W:0]      c_ext;
    logic [CNT_W:0]      c_sum;
    logic [CNT_W-1:0]    cnt_next;
    logic                beat_end;
    logic [LANE_W-1:0]   beat_end_lane;
    logic                beat_start;
    logic [LANE_W-1:0]   beat_start_lane;

    assign in_ready = ((phase_q == CON_WOR) || (phase_q == CON_DRN)) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // One extra bit keeps c+N from wrapping before the modulo subtraction.
    assign c_ext    = {1'b0, cnt_q};
    assign c_sum    = c_ext + N_EXT;
    assign cnt_next = (c_sum > L_EXT) ? CNT_W'(c_sum - L_EXT) : CNT_W'(c_sum);

    assign beat_end        = (c_ext < N_EXT) || (c_ext == L_EXT);
    assign beat_end_lane   = (c_ext == L_EXT) ? LAST_LANE : LANE_W'(N_EXT - c_ext - 1'b1);
    // A beat ending exactly on the codeword boundary carries no start; the next beat does.
    assign beat_start      = (c_ext == N_EXT) || ((c_ext < N_EXT) && (c_ext != L_EXT));
    assign beat_start_lane = (c_ext == N_EXT) ? '0 : LANE_W'(N_EXT - c_ext);

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            CON_IDL: phase_d = CON_PRE;
            CON_PRE: phase_d = CON_WOR;
            CON_WOR: if (dec_flush) phase_d = CON_DRN;
            CON_DRN: if (accept && beat_end) phase_d = CON_IDL;
            default: phase_d = CON_IDL;
        endcase
    end

    always_comb begin
        cnt_d            = cnt_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_end_d        = out_end_q;
        out_end_lane_d   = out_end_lane_q;
        out_start_d      = out_start_q;
        out_start_lane_d = out_start_lane_q;
        cw_d             = cw_q;

        if (phase_q == CON_PRE) begin
            cnt_d = N_CNT;
        end else if (accept) begin
            cnt_d = cnt_next;
        end

        if (accept) begin
            out_valid_d      = 1'b1;
            out_data_d       = in_data;
            out_end_d        = beat_end;
            out_end_lane_d   = beat_end_lane;
            out_start_d      = beat_start;
            out_start_lane_d = beat_start_lane;
            if (beat_end) cw_d = cw_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q          <= CON_IDL;
            cnt_q            <= N_CNT;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_end_q        <= 1'b0;
            out_end_lane_q   <= '0;
            out_start_q      <= 1'b0;
            out_start_lane_q <= '0;
            cw_q             <= '0;
        end else begin
            phase_q          <= phase_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_end_q        <= out_end_d;
            out_end_lane_q   <= out_end_lane_d;
            out_start_q      <= out_start_d;
            out_start_lane_q <= out_start_lane_d;
            cw_q             <= cw_d;
        end
    end

    assign dec_phase      = phase_q;
    assign dec_counter    = cnt_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_end        = out_end_q;
    assign out_end_lane   = out_end_lane_q;
    assign out_start      = out_start_q;
    assign out_start_lane = out_start_lane_q;
    assign cw_count       = cw_q;

endmodule

// File: tb/tb_dec_controller.sv
// Bench for dec_controller: a 255/16 instance checked against a symbol-position scoreboard,
// plus a 7/3 instance exercising the exact-boundary codeword case.
module tb_dec_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 255-symbol code, 16 lanes
    logic         in_valid, in_ready, dec_flush, out_valid, out_ready, out_end, out_start;
    logic [127:0] in_data, out_data;
    logic [1:0]   dec_phase;
    logic [7:0]   dec_counter;
    logic [3:0]   out_end_lane, out_start_lane;
    logic [15:0]  cw_count;

    // 7-symbol code, 3 lanes
    logic         in_valid7, in_ready7, dec_flush7, out_valid7, out_ready7, out_end7, out_start7;
    logic [23:0]  in_data7, out_data7;
    logic [1:0]   dec_phase7;
    logic [2:0]   dec_counter7;
    logic [1:0]   out_end_lane7, out_start_lane7;
    logic [15:0]  cw_count7;

    dec_controller #(.RS_COD_LEN(255), .DEC_SYM_NUM(16), .SYM_WID(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dec_flush(dec_flush), .dec_phase(dec_phase), .dec_counter(dec_counter),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_end(out_end), .out_end_lane(out_end_lane), .out_start(out_start),
        .out_start_lane(out_start_lane), .cw_count(cw_count)
    );

    dec_controller #(.RS_COD_LEN(7), .DEC_SYM_NUM(3), .SYM_WID(8)) dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7), .in_data(in_data7),
        .dec_flush(dec_flush7), .dec_phase(dec_phase7), .dec_counter(dec_counter7),
        .out_valid(out_valid7), .out_ready(out_ready7), .out_data(out_data7),
        .out_end(out_end7), .out_end_lane(out_end_lane7), .out_start(out_start7),
        .out_start_lane(out_start_lane7), .cw_count(cw_count7)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         e;
        logic [3:0]   el;
        logic         s;
        logic [3:0]   sl;
        logic [7:0]   cnt;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      obs_q[$];
    logic [7:0] obs_cnt_q[$];
    int         mdl_base;
    bit         mdl_drain;
    int         exp_cw;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference: symbol at lane i of a beat sits at stream position base+i; a codeword
    // ends where position mod L is L-1 and starts where it is 0.
    function automatic void lane_flags(input int base, input int n, input int l,
                                       output logic e, output int el,
                                       output logic s, output int sl);
        e = 1'b0; s = 1'b0; el = 0; sl = 0;
        for (int i = 0; i < n; i++) begin
            if ((base + i) % l == l - 1) begin e = 1'b1; el = i; end
            if ((base + i) % l == 0)     begin s = 1'b1; sl = i; end
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Advance one clock: handshakes are sampled at the falling edge, the model is
    // updated after the rising edge, and control returns 1 time unit after it.
    task automatic tick();
        bit           acc, fire;
        beat_t        ob, eb;
        logic [127:0] d_s;
        logic [7:0]   cnt_s;
        logic         e, s;
        int           el, sl;
        @(negedge clk);
        acc   = !rst && in_valid && in_ready;
        fire  = !rst && out_valid && out_ready;
        d_s   = in_data;
        cnt_s = dec_counter;
        ob.data = out_data; ob.e = out_end; ob.el = out_end_lane;
        ob.s = out_start; ob.sl = out_start_lane; ob.cnt = 8'd0;
        @(posedge clk);
        #1;
        if (fire) obs_q.push_back(ob);
        if (acc) begin
            lane_flags(mdl_base, 16, 255, e, el, s, sl);
            eb.data = d_s; eb.e = e; eb.el = 4'(el); eb.s = s; eb.sl = 4'(sl);
            eb.cnt = 8'(((mdl_base + 15) % 255) + 1);
            exp_q.push_back(eb);
            obs_cnt_q.push_back(cnt_s);
            if (e) exp_cw++;
            if (e && mdl_drain) begin
                mdl_base  = 0;
                mdl_drain = 1'b0;
            end else begin
                mdl_base = (mdl_base + 16) % 255;
            end
        end
    endtask

    task automatic model_clear();
        exp_q.delete(); obs_q.delete(); obs_cnt_q.delete();
        mdl_base = 0; mdl_drain = 1'b0; exp_cw = 0;
    endtask

    // Expects rst held high; checks reset values, releases rst and walks IDL, PRE, WOR.
    task automatic test_reset_sequence(input string tag);
        in_valid = 1'b1; out_ready = 1'b1; dec_flush = 1'b0; in_data = rand128();
        n_cmp++; if (dec_phase !== 2'd0) begin n_bad++; $display("FAIL %s_phase: got %0d want 0", tag, dec_phase); end
        n_cmp++; if (dec_counter !== 8'd16) begin n_bad++; $display("FAIL %s_cnt: got %0d want 16", tag, dec_counter); end
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 128'd0) begin n_bad++; $display("FAIL %s_out: got valid=%b data=%h want 0/0", tag, out_valid, out_data); end
        n_cmp++; if ({out_end, out_end_lane, out_start, out_start_lane} !== 10'd0) begin n_bad++; $display("FAIL %s_flags: got %b want 0", tag, {out_end, out_end_lane, out_start, out_start_lane}); end
        n_cmp++; if (cw_count !== 16'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_cw_rdy: got cw=%0d rdy=%b want 0/0", tag, cw_count, in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (dec_phase !== 2'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_idl: got phase=%0d rdy=%b want 0/0", tag, dec_phase, in_ready); end
        tick();
        n_cmp++; if (dec_phase !== 2'd1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_pre: got phase=%0d rdy=%b want 1/0", tag, dec_phase, in_ready); end
        tick();
        n_cmp++; if (dec_phase !== 2'd2 || in_ready !== 1'b1 || dec_counter !== 8'd16) begin n_bad++; $display("FAIL %s_wor: got phase=%0d rdy=%b cnt=%0d want 2/1/16", tag, dec_phase, in_ready, dec_counter); end
    endtask

    task automatic test_first_beat();
        logic [127:0] d;
        d = rand128();
        in_data = d;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== d) begin n_bad++; $display("FAIL first_data: got v=%b %h want 1 %h", out_valid, out_data, d); end
        n_cmp++; if (out_start !== 1'b1 || out_start_lane !== 4'd0 || out_end !== 1'b0) begin n_bad++; $display("FAIL first_flags: got s=%b sl=%0d e=%b want 1/0/0", out_start, out_start_lane, out_end); end
        n_cmp++; if (dec_counter !== 8'd32) begin n_bad++; $display("FAIL first_cnt: got %0d want 32", dec_counter); end
    endtask

    task automatic test_stream16();
        for (int k = 1; k < 16; k++) begin
            in_data = rand128();
            n_cmp++; if (dec_counter !== 8'(((16 * k + 15) % 255) + 1)) begin n_bad++; $display("FAIL stream_cnt%0d: got %0d want %0d", k, dec_counter, ((16 * k + 15) % 255) + 1); end
            tick();
        end
        n_cmp++; if (out_end !== 1'b1 || out_end_lane !== 4'd14) begin n_bad++; $display("FAIL stream_end: got e=%b el=%0d want 1/14", out_end, out_end_lane); end
        n_cmp++; if (out_start !== 1'b1 || out_start_lane !== 4'd15) begin n_bad++; $display("FAIL stream_start: got s=%b sl=%0d want 1/15", out_start, out_start_lane); end
        n_cmp++; if (cw_count !== 16'd1) begin n_bad++; $display("FAIL stream_cw: got %0d want 1", cw_count); end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        out_ready = 1'b0; in_valid = 1'b1; in_data = rand128();
        #1;
        held = out_data;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy0: got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            in_data = rand128();
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin n_bad++; $display("FAIL bp_hold%0d: got rdy=%b v=%b %h want 0/1 %h", i, in_ready, out_valid, out_data, held); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = rand128();
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_thru%0d: got rdy=%b want 1", i, in_ready); end
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); in_data = rand128();
            tick();
        end
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        int guard = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (mdl_base != 80 && guard < 300) begin
            in_data = rand128();
            tick();
            guard++;
        end
        n_cmp++; if (mdl_base != 80) begin n_bad++; $display("FAIL flush_reach: got base=%0d want 80", mdl_base); end
        n_cmp++; if (dec_counter !== 8'd96) begin n_bad++; $display("FAIL flush_cnt: got %0d want 96", dec_counter); end
        dec_flush = 1'b1; in_data = rand128();
        tick();
        mdl_drain = 1'b1;
        n_cmp++; if (dec_phase !== 2'd3) begin n_bad++; $display("FAIL flush_drn: got %0d want 3", dec_phase); end
        for (int i = 0; i < 10; i++) begin
            in_data = rand128();
            n_cmp++; if (dec_phase !== 2'd3 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_drn%0d: got phase=%0d rdy=%b want 3/1", i, dec_phase, in_ready); end
            tick();
        end
        n_cmp++; if (dec_phase !== 2'd0 || in_ready !== 1'b0 || out_end !== 1'b1) begin n_bad++; $display("FAIL flush_idl: got phase=%0d rdy=%b e=%b want 0/0/1", dec_phase, in_ready, out_end); end
        tick();
        dec_flush = 1'b0;
        n_cmp++; if (dec_phase !== 2'd1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre: got phase=%0d rdy=%b want 1/0", dec_phase, in_ready); end
        tick();
        n_cmp++; if (dec_phase !== 2'd2 || dec_counter !== 8'd16) begin n_bad++; $display("FAIL flush_wor: got phase=%0d cnt=%0d want 2/16", dec_phase, dec_counter); end
        for (int i = 0; i < 20; i++) begin
            in_data = rand128();
            tick();
        end
    endtask

    task automatic test_scoreboard();
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL sb_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("beat %0d cnt=%0d end=%b/%0d start=%b/%0d data=%h", i, obs_cnt_q[i], obs_q[i].e, obs_q[i].el, obs_q[i].s, obs_q[i].sl, obs_q[i].data);
            n_cmp++; if (obs_q[i].data !== exp_q[i].data) begin n_bad++; $display("FAIL sb_data%0d: got %h want %h", i, obs_q[i].data, exp_q[i].data); end
            n_cmp++; if (obs_cnt_q[i] !== exp_q[i].cnt) begin n_bad++; $display("FAIL sb_cnt%0d: got %0d want %0d", i, obs_cnt_q[i], exp_q[i].cnt); end
            n_cmp++; if (obs_q[i].e !== exp_q[i].e || (exp_q[i].e && obs_q[i].el !== exp_q[i].el)) begin n_bad++; $display("FAIL sb_end%0d: got %b/%0d want %b/%0d", i, obs_q[i].e, obs_q[i].el, exp_q[i].e, exp_q[i].el); end
            n_cmp++; if (obs_q[i].s !== exp_q[i].s || (exp_q[i].s && obs_q[i].sl !== exp_q[i].sl)) begin n_bad++; $display("FAIL sb_start%0d: got %b/%0d want %b/%0d", i, obs_q[i].s, obs_q[i].sl, exp_q[i].s, exp_q[i].sl); end
        end
        n_cmp++; if (cw_count !== 16'(exp_cw)) begin n_bad++; $display("FAIL sb_cw: got %0d want %0d", cw_count, exp_cw); end
        exp_q.delete(); obs_q.delete(); obs_cnt_q.delete();
    endtask

    task automatic test_small_code();
        int           base;
        logic         e, s;
        int           el, sl;
        logic [23:0]  d;
        in_valid7 = 1'b1; out_ready7 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            base = (3 * k) % 7;
            d = 24'($urandom());
            in_data7 = d;
            n_cmp++; if (dec_counter7 !== 3'(((base + 2) % 7) + 1) || in_ready7 !== 1'b1) begin n_bad++; $display("FAIL small_cnt%0d: got %0d rdy=%b want %0d/1", k, dec_counter7, in_ready7, ((base + 2) % 7) + 1); end
            tick();
            lane_flags(base, 3, 7, e, el, s, sl);
            n_cmp++; if (out_valid7 !== 1'b1 || out_data7 !== d) begin n_bad++; $display("FAIL small_data%0d: got v=%b %h want 1 %h", k, out_valid7, out_data7, d); end
            n_cmp++; if (out_end7 !== e || (e && out_end_lane7 !== 2'(el))) begin n_bad++; $display("FAIL small_end%0d: got %b/%0d want %b/%0d", k, out_end7, out_end_lane7, e, el); end
            n_cmp++; if (out_start7 !== s || (s && out_start_lane7 !== 2'(sl))) begin n_bad++; $display("FAIL small_start%0d: got %b/%0d want %b/%0d", k, out_start7, out_start_lane7, s, sl); end
        end
        in_valid7 = 1'b0;
        n_cmp++; if (cw_count7 !== 16'd3) begin n_bad++; $display("FAIL small_cw: got %0d want 3", cw_count7); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = rand128();
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || dec_phase !== 2'd0 || dec_counter !== 8'd16 || cw_count !== 16'd0) begin n_bad++; $display("FAIL arst_now: got v=%b phase=%0d cnt=%0d cw=%0d want 0/0/16/0", out_valid, dec_phase, dec_counter, cw_count); end
        @(posedge clk);
        #1;
        model_clear();
        test_reset_sequence("arst");
        test_first_beat();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; dec_flush = 1'b0; in_data = '0;
        in_valid7 = 1'b0; out_ready7 = 1'b1; dec_flush7 = 1'b0; in_data7 = '0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset_sequence("reset");
        test_first_beat();
        test_stream16();
        test_backpressure();
        test_flush();
        test_scoreboard();
        test_small_code();
        test_async_reset();
        in_valid = 1'b0;
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_controller.md
Name: dec_controller

Overview:
- Input-side sequencing controller of the RS decoder: mirror of the encoder controller.
- Accepts the received symbol stream, DEC_SYM_NUM symbols per beat, and tracks each beat's position inside the RS_COD_LEN-symbol codeword.
- Flags the lanes where codewords end and start, and forwards data plus flags through a one-beat register slice to the syndrome stage.
- Supports a drain request that stops accepting input at the next codeword boundary, then re-arms.

Parameters:
- RS_COD_LEN, 255, codeword length in symbols.
- DEC_SYM_NUM, 16, symbols per beat. Legal range 1..RS_COD_LEN.
- SYM_WID, 8, bits per symbol.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DEC_SYM_NUM*SYM_WID  beat data. Lane 0 is in the LSBs and is the first symbol received.
- dec_flush  in  1  drain request, sampled in WOR.
- dec_phase  out  2  CON_PHASE encoding: CON_IDL, CON_PRE, CON_WOR, CON_DRN.
- dec_counter  out  $clog2(RS_COD_LEN+1)  codeword end-position of the beat now on in_data, range 1..RS_COD_LEN.
- out_valid  in/out: out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DEC_SYM_NUM*SYM_WID  registered copy of the accepted beat.
- out_end  out  1  a codeword ends within this beat.
- out_end_lane  out  $clog2(DEC_SYM_NUM)  lane of the last symbol of the ending codeword.
- out_start  out  1  a codeword starts within this beat.
- out_start_lane  out  $clog2(DEC_SYM_NUM)  lane of the first symbol of the new codeword.
- cw_count  out  16  number of completed codewords, wraps at 2^16.

Behaviour:
- Reset (async, active-high) sets:
  - dec_phase=CON_IDL, dec_counter=DEC_SYM_NUM
  - out_valid=0; out_data, flags and lanes =0
  - cw_count=0, in_ready=0
- FSM:
  - IDL → PRE unconditionally on the next clk.
  - PRE → WOR. In PRE, dec_counter loads DEC_SYM_NUM.
  - WOR → DRN when dec_flush=1, otherwise stays in WOR.
  - DRN → IDL on the cycle a beat with end=1 is accepted.
  - Illegal encoding → IDL.
- in_ready = (phase is WOR or DRN) && (!out_valid || out_ready). It is 0 in IDL and PRE.
- Counter update happens on each accepted beat only; it holds otherwise. Let c = dec_counter and N = DEC_SYM_NUM:
  - next c = c+N-RS_COD_LEN if c+N > RS_COD_LEN, else c+N.
  - Arithmetic is one bit wider than dec_counter, so there is no overflow.
- Flags computed from c for the accepted beat:
  - end = (c < N) || (c == RS_COD_LEN).
  - end_lane = N-1 if c == RS_COD_LEN, else N-c-1.
  - start = (c <= N). This includes the first beat after PRE (c == N, start_lane=0).
  - start_lane = 0 if c == N, else N-c.
  - When c == RS_COD_LEN, start=0 for this beat; the next beat has c == N and start_lane=0.
  - Both end and start may be set in the same beat.
- Register slice, 1-cycle latency:
  - On accept, out_data and the flags load and out_valid is set.
  - out_valid clears when out_ready=1 and no new beat is accepted in that cycle.
  - Output holds stable while out_valid && !out_ready.
- cw_count increments on each accepted beat with end=1.
- Flush:
  - If dec_flush is asserted in the same cycle as an accepted end beat in WOR, the beat is processed and the FSM goes to DRN.
  - DRN then waits for the next end beat (full next codeword).
  - dec_flush is ignored outside WOR.
- The re-arm path (DRN→IDL→PRE→WOR) reloads dec_counter = N. The stream is assumed codeword-aligned after a drain.
- The register slice continues to drain downstream during IDL and PRE.
- Reset mid-operation discards the beat held in the register slice. There is no partial-codeword recovery.

Test Plan:
- Reset, then idle with in_valid=1 → in_ready=0 for 2 cycles (IDL, PRE), then 1 in WOR; dec_counter=16 in WOR before the first accept; first output start=1, start_lane=0, end=0.
- RS_COD_LEN=255, N=16, 16 consecutive beats → dec_counter sequence 16,32,…,240, then 1. The 16th beat (c=1) gives end=1, end_lane=14, start=1, start_lane=15; cw_count=1.
- RS_COD_LEN=7, N=3, stream of beats → c = 3,6,2,5,1,4,7,3. Beat c=7 gives end_lane=2, start=0; next beat c=3 gives start_lane=0. cw_count=3 after 8 beats.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → exactly one beat held, in_ready=0, out_data stable. Releasing out_ready gives throughput of 1 beat/cycle with no loss or duplication (scoreboard check).
- Flush: pulse dec_flush mid-codeword (N=16, c=96) → phase DRN; accepts continue until the c=1 beat; then IDL, PRE, WOR with dec_counter=16.
- Assert rst asynchronously mid-stream (not clock-aligned) → all outputs reach reset values immediately; restart sequence identical to the first scenario.
